// File: rtl/game_sequencer_pkg.sv
// Shared types and constants for the game sequencer slice.
// State encoding, house codes, target count and a hit popcount.
package game_sequencer_pkg;

  localparam int NUM_TARGETS = 25;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READY    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_TIMES_UP = 3'd3,
    ST_LEADER   = 3'd4
  } state_t;

  localparam logic [1:0] HOUSE_G = 2'd0;
  localparam logic [1:0] HOUSE_S = 2'd1;
  localparam logic [1:0] HOUSE_H = 2'd2;
  localparam logic [1:0] HOUSE_R = 2'd3;

  function automatic logic [4:0] hit_count(
    input logic [NUM_TARGETS-1:0] v
  );
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NUM_TARGETS; i++)
      n = n + 5'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/game_sequencer_ir_debounce.sv
// One IR receiver channel: 2-flop synchronizer, debounce counter,
// stable level and a registered one-cycle falling-edge (hit) pulse.
module ir_debounce #(
  parameter int DB_CYCLES = 50_000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_n,
  output logic fall
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          sync0;
  logic          sync1;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync0  <= 1'b1;
      sync1  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      fall   <= 1'b0;
    end else begin
      sync0 <= raw_n;
      sync1 <= sync0;
      fall  <= 1'b0;
      // Any sample matching the stable level restarts the run.
      if (sync1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync1;
        cnt    <= '0;
        fall   <= ~sync1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Round sequencer: IR front end, phase FSM with a one-second
// prescaler, hit map and score for the VGA display controller.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int READY_SECS = 3,
  parameter int GAME_SECS  = 30,
  parameter int SHOW_SECS  = 5,
  parameter int DB_CYCLES  = 50_000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_TARGETS-1:0] ir_raw_n,
  input  logic [1:0]             house_sel,
  input  logic                   house_valid,
  output logic [NUM_TARGETS-1:0] ir_in,
  output logic                   G,
  output logic                   S,
  output logic                   H,
  output logic                   R,
  output logic                   get_ready,
  output logic                   times_up,
  output logic                   leaderboard,
  output logic [4:0]             score,
  output logic [6:0]             secs_left
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t                 state;
  state_t                 state_d;
  logic [PW-1:0]          presc;
  logic [6:0]             remain;
  logic [3:0]             house;
  logic [3:0]             house_dec;
  logic                   tick;
  logic                   start;
  logic                   last;
  logic [NUM_TARGETS-1:0] fall;
  logic [NUM_TARGETS-1:0] new_hits;

  for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_db
    ir_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clock(clock),
      .reset(reset),
      .raw_n(ir_raw_n[i]),
      .fall (fall[i])
    );
  end

  assign tick  = (presc == PRESC_MAX);
  assign last  = tick && (remain == 7'd1);
  assign start = house_valid &&
                 (state == ST_IDLE || state == ST_LEADER);
  assign new_hits = (state == ST_PLAY) ? (fall & ~ir_in) : '0;

  assign {R, H, S, G} = house;
  assign secs_left = (state == ST_PLAY) ? remain : '0;

  always_comb begin
    house_dec = 4'b0000;
    unique case (house_sel)
      HOUSE_G: house_dec = 4'b0001;
      HOUSE_S: house_dec = 4'b0010;
      HOUSE_H: house_dec = 4'b0100;
      HOUSE_R: house_dec = 4'b1000;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE,
      ST_LEADER:   if (start) state_d = ST_READY;
      ST_READY:    if (last)  state_d = ST_PLAY;
      ST_PLAY:     if (last)  state_d = ST_TIMES_UP;
      ST_TIMES_UP: if (last)  state_d = ST_LEADER;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      presc       <= '0;
      remain      <= '0;
      house       <= '0;
      ir_in       <= '0;
      score       <= '0;
      get_ready   <= 1'b0;
      times_up    <= 1'b0;
      leaderboard <= 1'b0;
    end else begin
      state       <= state_d;
      get_ready   <= (state_d == ST_READY);
      times_up    <= (state_d == ST_TIMES_UP);
      leaderboard <= (state_d == ST_LEADER);
      // Every phase is timed from a fresh prescaler at its entry edge.
      if (state_d != state) begin
        presc <= '0;
        case (state_d)
          ST_READY:    remain <= 7'(READY_SECS);
          ST_PLAY:     remain <= 7'(GAME_SECS);
          ST_TIMES_UP: remain <= 7'(SHOW_SECS);
          default:     remain <= '0;
        endcase
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick && remain != '0)
          remain <= remain - 7'd1;
      end
      if (start) begin
        house <= house_dec;
        ir_in <= '0;
        score <= '0;
      end else begin
        ir_in <= ir_in | new_hits;
        score <= score + hit_count(new_hits);
      end
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed phase/hit scenarios plus randomized
// rounds checked each cycle against a timeline model of the round.
module tb_game_sequencer;

  localparam int TICK = 10;
  localparam int RS   = 3;
  localparam int GS   = 5;
  localparam int SS   = 2;
  localparam int DB   = 4;
  localparam int T_PLAY = RS * TICK;
  localparam int T_TU   = T_PLAY + GS * TICK;
  localparam int T_LB   = T_TU + SS * TICK;
  localparam int HIT_LAT = 2 + DB + 1;

  logic        clock;
  logic        reset;
  logic [24:0] ir_raw_n;
  logic [1:0]  house_sel;
  logic        house_valid;
  logic [24:0] ir_in;
  logic        G, S, H, R;
  logic        get_ready, times_up, leaderboard;
  logic [4:0]  score;
  logic [6:0]  secs_left;

  int total;
  int bad;
  int k;

  wire [43:0] all_out = {ir_in, G, S, H, R, get_ready, times_up,
                         leaderboard, score, secs_left};

  game_sequencer #(
    .TICK_DIV(TICK), .READY_SECS(RS), .GAME_SECS(GS),
    .SHOW_SECS(SS), .DB_CYCLES(DB)
  ) dut (
    .clock(clock), .reset(reset), .ir_raw_n(ir_raw_n),
    .house_sel(house_sel), .house_valid(house_valid),
    .ir_in(ir_in), .G(G), .S(S), .H(H), .R(R),
    .get_ready(get_ready), .times_up(times_up),
    .leaderboard(leaderboard), .score(score),
    .secs_left(secs_left)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    k++;
  endtask

  task automatic go_to(input int t);
    while (k < t) step();
  endtask

  task automatic start_round(input logic [1:0] sel);
    house_sel   = sel;
    house_valid = 1'b1;
    @(posedge clock);
    #1;
    house_valid = 1'b0;
    k = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ir_raw_n = '1;
    house_sel = 2'd0;
    house_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (all_out !== 44'd0) begin
      bad++;
      $display("FAIL reset_values got=%h want=0", all_out);
    end
    reset = 1'b0;
    repeat (4) step();
    total++;
    if (all_out !== 44'd0) begin
      bad++;
      $display("FAIL idle_after_reset got=%h want=0", all_out);
    end
  endtask

  // Per-cycle model: phase from elapsed cycles, hits from press timeline.
  task automatic run_model_round(input logic [1:0] sel, input bit hits);
    logic [24:0] plan [120];
    int          hit_at [25];
    logic [24:0] exp_ir;
    logic [3:0]  hx;
    logic [43:0] exp_v;
    logic [6:0]  exp_secs;
    bit          play;
    for (int c = 0; c < 120; c++) plan[c] = '0;
    for (int ch = 0; ch < 25; ch++) hit_at[ch] = -1;
    if (hits) begin
      for (int ch = 0; ch < 23; ch++) begin
        int s, len, n;
        n = $urandom_range(0, 2);
        s = $urandom_range(0, 90);
        for (int p = 0; p < n; p++) begin
          len = $urandom_range(1, 7);
          if (s + len <= 100) begin
            for (int t = s; t < s + len; t++) plan[t][ch] = 1'b1;
            if (len >= DB && hit_at[ch] < 0 &&
                s + HIT_LAT - 1 >= T_PLAY && s + HIT_LAT - 1 < T_TU)
              hit_at[ch] = s + HIT_LAT;
          end
          s = s + len + 8 + $urandom_range(0, 10);
        end
      end
      for (int t = T_TU - HIT_LAT; t < T_TU - HIT_LAT + 5; t++)
        plan[t][24] = 1'b1;
      hit_at[24] = T_TU;
      for (int t = T_TU - HIT_LAT + 1; t < T_TU - HIT_LAT + 6; t++)
        plan[t][23] = 1'b1;
    end
    hx = 4'b0001 << sel;
    start_round(sel);
    for (int c = 0; c < 120; c++) begin
      ir_raw_n = ~plan[c];
      exp_ir = '0;
      for (int ch = 0; ch < 25; ch++)
        if (hit_at[ch] >= 0 && hit_at[ch] <= c) exp_ir[ch] = 1'b1;
      play = (c >= T_PLAY && c < T_TU);
      exp_secs = play ? 7'(GS - (c - T_PLAY) / TICK) : 7'd0;
      exp_v = {exp_ir, hx[0], hx[1], hx[2], hx[3],
               c < T_PLAY, play ? 1'b0 : (c >= T_TU && c < T_LB),
               c >= T_LB, 5'($countones(exp_ir)), exp_secs};
      total++;
      if (all_out !== exp_v) begin
        bad++;
        $display("FAIL round_cycle%0d got=%h want=%h", c, all_out, exp_v);
      end
      step();
    end
    ir_raw_n = '1;
  endtask

  task automatic test_full_round();
    run_model_round(2'd2, 1'b0);
  endtask

  task automatic test_hits();
    start_round(2'd2);
    go_to(31);
    ir_raw_n[7] = 1'b0;
    go_to(37);
    total++;
    if (ir_in[7] !== 1'b0) begin
      bad++;
      $display("FAIL hit_early got=%b want=0", ir_in[7]);
    end
    step();
    total++;
    if ({ir_in[7], score} !== {1'b1, 5'd1}) begin
      bad++;
      $display("FAIL hit_latency got=%b/%0d want=1/1", ir_in[7], score);
    end
    go_to(41);
    ir_raw_n[7] = 1'b1;
    go_to(50);
    ir_raw_n[7] = 1'b0;
    go_to(56);
    ir_raw_n[7] = 1'b1;
    go_to(60);
    total++;
    if (score !== 5'd1) begin
      bad++;
      $display("FAIL repeat_hit score=%0d want=1", score);
    end
    ir_raw_n[0] = 1'b0;
    ir_raw_n[24] = 1'b0;
    go_to(65);
    ir_raw_n = '1;
    go_to(67);
    total++;
    if ({ir_in, score} !== {25'h1000081, 5'd3}) begin
      bad++;
      $display("FAIL simul_hit got=%h/%0d want=1000081/3", ir_in, score);
    end
    go_to(110);
    total++;
    if ({leaderboard, H, ir_in, score} !== {2'b11, 25'h1000081, 5'd3}) begin
      bad++;
      $display("FAIL leader_hold got=%b%b/%h/%0d", leaderboard, H,
               ir_in, score);
    end
  endtask

  task automatic test_bounce();
    start_round(2'd1);
    go_to(2);
    ir_raw_n[5] = 1'b0;
    go_to(8);
    ir_raw_n[5] = 1'b1;
    go_to(32);
    for (int r = 0; r < 5; r++) begin
      ir_raw_n[3] = 1'b0;
      repeat (3) step();
      ir_raw_n[3] = 1'b1;
      step();
    end
    go_to(60);
    total++;
    if ({ir_in, score} !== 30'd0) begin
      bad++;
      $display("FAIL bounce got=%h/%0d want=0/0", ir_in, score);
    end
    go_to(82);
    ir_raw_n[9] = 1'b0;
    go_to(88);
    ir_raw_n[9] = 1'b1;
    go_to(T_LB);
    total++;
    if ({leaderboard, S, ir_in, score} !== {2'b11, 30'd0}) begin
      bad++;
      $display("FAIL off_phase_hit got=%b%b/%h/%0d", leaderboard, S,
               ir_in, score);
    end
  endtask

  task automatic test_ignored_request();
    start_round(2'd2);
    go_to(40);
    house_sel = 2'd0;
    house_valid = 1'b1;
    step();
    house_valid = 1'b0;
    total++;
    if ({G, H, get_ready, secs_left} !== {3'b010, 7'd4}) begin
      bad++;
      $display("FAIL ignored_req got=%b%b%b/%0d want=010/4", G, H,
               get_ready, secs_left);
    end
    go_to(45);
    ir_raw_n[2] = 1'b0;
    go_to(50);
    ir_raw_n[2] = 1'b1;
    go_to(T_TU - 1);
    total++;
    if ({times_up, secs_left} !== {1'b0, 7'd1}) begin
      bad++;
      $display("FAIL last_play got=%b/%0d want=0/1", times_up, secs_left);
    end
    step();
    total++;
    if ({times_up, secs_left} !== {1'b1, 7'd0}) begin
      bad++;
      $display("FAIL times_up_entry got=%b/%0d want=1/0", times_up,
               secs_left);
    end
    go_to(T_LB);
    total++;
    if ({leaderboard, ir_in, score} !== {1'b1, 25'h4, 5'd1}) begin
      bad++;
      $display("FAIL leader_before got=%b/%h/%0d", leaderboard, ir_in,
               score);
    end
    start_round(2'd0);
    total++;
    if ({G, H, get_ready, leaderboard, ir_in, score} !==
        {4'b1010, 30'd0}) begin
      bad++;
      $display("FAIL restart got=%b%b%b%b/%h/%0d", G, H, get_ready,
               leaderboard, ir_in, score);
    end
    go_to(T_LB);
  endtask

  task automatic test_random();
    run_model_round(2'($urandom_range(0, 3)), 1'b1);
  endtask

  task automatic test_reset_mid();
    start_round(2'd3);
    go_to(35);
    ir_raw_n[4:1] = 4'b0000;
    go_to(40);
    ir_raw_n = '1;
    go_to(45);
    total++;
    if (score !== 5'd4) begin
      bad++;
      $display("FAIL pre_reset_score got=%0d want=4", score);
    end
    #3;
    reset = 1'b1;
    #1;
    total++;
    if (all_out !== 44'd0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0", all_out);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (5) step();
    total++;
    if (all_out !== 44'd0) begin
      bad++;
      $display("FAIL idle_after_abort got=%h want=0", all_out);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    k = 0;
    test_reset();
    test_full_round();
    test_hits();
    test_bounce();
    test_ignored_request();
    test_random();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Game-flow controller and IR target front end that produces the display control set the VGA controller consumes:
- target hit map `ir_in[24:0]`
- house selects `G`/`S`/`H`/`R`
- phase flags `get_ready`, `times_up`, `leaderboard`

It sits between the 25 raw IR receiver pins and the graphics top level. It debounces the receiver pins, sequences the round timing and accumulates the score.

## Interface
- `TICK_DIV`, 50_000_000 — clock cycles per one-second tick.
- `READY_SECS`, 3 — length of the READY phase, in ticks.
- `GAME_SECS`, 30 — length of the PLAY phase, in ticks (max 127).
- `SHOW_SECS`, 5 — length of the TIMES_UP phase, in ticks.
- `DB_CYCLES`, 50_000 — consecutive identical samples required to accept a receiver level change.

Ports:
- `clock` in 1 — single clock, all logic on rising edge.
- `reset` in 1 — asynchronous, active-high.
- `ir_raw_n` in 25 — raw IR receiver outputs, asynchronous, active-low (0 = beam hit).
- `house_sel` in 2 — house code: 0 = G, 1 = S, 2 = H, 3 = R.
- `house_valid` in 1 — one-cycle request to start a round with `house_sel`.
- `ir_in` out 25 — latched per-target hit map for the display.
- `G`, `S`, `H`, `R` out 1 each — one-hot current house.
- `get_ready`, `times_up`, `leaderboard` out 1 each — phase flags.
- `score` out 5 — count of distinct targets hit this round (0..25).
- `secs_left` out 7 — remaining PLAY seconds; 0 outside PLAY.

## Operation
- **Input conditioning.** Each `ir_raw_n` bit goes through a 2-flop synchronizer, then a debounce counter.
  - The stable level updates only after DB_CYCLES consecutive samples that differ from it.
  - The stable level resets to 1 (no hit).
  - A hit event is a 1→0 transition of the stable level.
- **States:** IDLE, READY, PLAY, TIMES_UP, LEADER.
- **IDLE** (from reset). All flags 0.
  - `house_valid` latches the house one-hot, clears `ir_in` and `score`, then enters READY.
- **READY.** `get_ready`=1. After READY_SECS ticks, enter PLAY with `secs_left`=GAME_SECS.
- **PLAY.**
  - A hit event on target k with `ir_in[k]`=0 sets `ir_in[k]` and increments `score`.
  - A repeat hit on an already-set target is ignored.
  - Simultaneous hits on several targets all count in the same cycle; `score` adds their popcount.
  - Each tick decrements `secs_left`. The tick that makes it 0 enters TIMES_UP.
- **TIMES_UP.** `times_up`=1. `ir_in` and `score` are frozen. After SHOW_SECS ticks, enter LEADER.
- **LEADER.** `leaderboard`=1. `ir_in`, `score` and house are held.
  - `house_valid` starts a new round exactly as from IDLE.
- `house_valid` in READY, PLAY or TIMES_UP is ignored.
- Hit events outside PLAY are ignored. The debouncers keep running in every state.

## Timing
- **Reset values:**
  - `ir_in`=0, house outputs=0, all flags=0, `score`=0, `secs_left`=0, state IDLE.
  - Prescaler 0; all debounce stable levels 1.
- **Reset mid-round** aborts immediately and asynchronously to these values.
- **Prescaler.** Cleared on every state entry. A tick pulses when it reaches TICK_DIV−1. Phase durations are therefore exact multiples of TICK_DIV cycles from the entry edge.
- `house_valid` at edge n:
  - the house one-hot and `get_ready` are valid after edge n;
  - `ir_in`/`score` are cleared at the same edge.
- Phase flags are registered and mutually exclusive; exactly one is high outside IDLE.
- **Hit latency.** `ir_raw_n` falling to `ir_in` set takes 2 synchronizer cycles + DB_CYCLES + 1 register cycle.
- **End of PLAY.** A hit event in the last PLAY cycle, the same edge as the final tick, counts.

## Structure
- A shared package holds:
  - the state enum;
  - the house code constants (G=0, S=1, H=2, R=3);
  - `NUM_TARGETS`=25.
- One sub-module, `ir_debounce`: a single channel with synchronizer, counter, stable level and fall-edge pulse. It is instantiated 25× via generate.
- The sequencer FSM, prescaler and score logic sit in `game_sequencer`.

## Test plan
Parameters: TICK_DIV=10, READY_SECS=3, GAME_SECS=5, SHOW_SECS=2, DB_CYCLES=4.

1. **Full round.** Pulse `house_valid` with `house_sel`=2.
   - Expect `H`=1 at once, then `get_ready` for 30 cycles, PLAY for 50 cycles with `secs_left` 5→0, `times_up` for 20 cycles, then `leaderboard`=1 held.
2. **Hits.** During PLAY, drive `ir_raw_n[7]` low for 10 cycles.
   - `ir_in[7]` sets 7 cycles after the fall and `score`=1.
   - A second press of target 7 leaves `score` at 1.
   - Simultaneous presses of targets 0 and 24 give `score`=3.
3. **Bounce.** Toggle `ir_raw_n[3]` low for 3 cycles, high for 1, repeatedly → no hit.
   - A hit during READY or TIMES_UP → `ir_in` unchanged.
4. **Ignored request.** `house_valid` with `house_sel`=0 during PLAY → `H` stays set and the timing is unchanged.
   - In LEADER, the same request gives `G`=1, `ir_in`=0, `score`=0 and `get_ready`=1.
5. **Reset mid-round.** Assert `reset` mid-PLAY with `score`=4 → all outputs 0 immediately.
   - After release, state is IDLE and no flag is high.
